// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - fetch-stage program counter with start/done sequencing
// Drives the instruction ROM address and counts the cycles spent executing.
module prog_counter #(
   parameter int D  = 10,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Halt,
   input  logic          Stall,
   input  logic          BranchAbs,
   input  logic [D-1:0]  Target,
   input  logic          BranchRel,
   input  logic [7:0]    Offset,
   output logic [D-1:0]  prog_ctr,
   output logic          Done,
   output logic          Running,
   output logic [CW-1:0] CycleCount
);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

   state_t         state, state_next;
   logic [D-1:0]   pc_next;
   logic [D-1:0]   offset_ext;

   assign offset_ext = D'($signed(Offset));

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = ARM;
         ARM:     if (!Start) state_next = RUN;
         RUN:     if (Halt) state_next = DONE;
         DONE:    if (Start) state_next = ARM;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Running = (state == RUN);
      Done    = (state == DONE);
   end

   // Halt outranks everything so the halting instruction's address stays visible in DONE.
   always_comb begin
      pc_next = prog_ctr + D'(1);
      if (Halt || Stall) pc_next = prog_ctr;
      else if (BranchAbs) pc_next = Target;
      else if (BranchRel) pc_next = prog_ctr + offset_ext;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         prog_ctr   <= '0;
         CycleCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               prog_ctr <= '0;
               if (Start) CycleCount <= '0;
            end
            ARM: begin
               prog_ctr   <= '0;
               CycleCount <= '0;
            end
            RUN: begin
               prog_ctr <= pc_next;
               if (CycleCount != {CW{1'b1}}) CycleCount <= CycleCount + CW'(1);
            end
            DONE: begin
               if (Start) begin
                  prog_ctr   <= '0;
                  CycleCount <= '0;
               end
            end
            default: prog_ctr <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - directed self-checking bench for prog_counter
// A second instance with CW=4 shares the stimulus to exercise counter saturation.
module tb_prog_counter;
   logic        Clk = 1'b0;
   logic        Reset, Start, Halt, Stall, BranchAbs, BranchRel;
   logic [9:0]  Target;
   logic [7:0]  Offset;
   logic [9:0]  prog_ctr, prog_ctr_s;
   logic        Done, Running, Done_s, Running_s;
   logic [15:0] CycleCount;
   logic [3:0]  CycleCount_s;
   int          checks = 0;
   int          errors = 0;

   always #5 Clk = ~Clk;

   prog_counter #(.D(10), .CW(16)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
      .BranchAbs(BranchAbs), .Target(Target), .BranchRel(BranchRel), .Offset(Offset),
      .prog_ctr(prog_ctr), .Done(Done), .Running(Running), .CycleCount(CycleCount)
   );

   prog_counter #(.D(10), .CW(4)) dut_small (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
      .BranchAbs(BranchAbs), .Target(Target), .BranchRel(BranchRel), .Offset(Offset),
      .prog_ctr(prog_ctr_s), .Done(Done_s), .Running(Running_s), .CycleCount(CycleCount_s)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_ctl();
      Halt = 0; Stall = 0; BranchAbs = 0; BranchRel = 0; Target = '0; Offset = '0;
   endtask

   task automatic jump_to(input logic [9:0] t);
      BranchAbs = 1; Target = t;
      step();
      clear_ctl();
   endtask

   task automatic test_reset();
      Reset = 1; Start = 0; clear_ctl();
      step(); step();
      Reset = 0;
      checks++;
      if (prog_ctr !== 10'd0 || Done !== 1'b0 || Running !== 1'b0 || CycleCount !== 16'd0) begin
         errors++;
         $display("FAIL reset: pc=%0d done=%b run=%b cnt=%0d, want 0 0 0 0", prog_ctr, Done, Running, CycleCount);
      end
   endtask

   task automatic test_sequential();
      Start = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (prog_ctr !== 10'd0 || Running !== 1'b0) begin
            errors++;
            $display("FAIL arm: pc=%0d run=%b, want 0 0", prog_ctr, Running);
         end
      end
      Start = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (prog_ctr !== 10'(i) || Running !== 1'b1 || CycleCount !== 16'(i)) begin
            errors++;
            $display("FAIL seq[%0d]: pc=%0d run=%b cnt=%0d, want %0d 1 %0d", i, prog_ctr, Running, CycleCount, i, i);
         end
         step();
      end
      checks++;
      if (CycleCount !== 16'd5 || prog_ctr !== 10'd5) begin
         errors++;
         $display("FAIL seq_count: cnt=%0d pc=%0d, want 5 5", CycleCount, prog_ctr);
      end
   endtask

   task automatic test_branch();
      jump_to(10'd20);
      BranchRel = 1; Offset = 8'hF6;
      step();
      checks++;
      if (prog_ctr !== 10'd10) begin
         errors++;
         $display("FAIL rel_neg: pc=%0d, want 10", prog_ctr);
      end
      Offset = 8'h7F;
      step();
      checks++;
      if (prog_ctr !== 10'd137) begin
         errors++;
         $display("FAIL rel_pos: pc=%0d, want 137", prog_ctr);
      end
      BranchAbs = 1; Target = 10'd900; BranchRel = 1; Offset = 8'h05;
      step();
      clear_ctl();
      checks++;
      if (prog_ctr !== 10'd900) begin
         errors++;
         $display("FAIL abs_wins: pc=%0d, want 900", prog_ctr);
      end
   endtask

   task automatic test_stall();
      logic [15:0] c0;
      jump_to(10'd7);
      c0 = CycleCount;
      Stall = 1;
      step(); step(); step();
      checks++;
      if (prog_ctr !== 10'd7 || CycleCount !== c0 + 16'd3) begin
         errors++;
         $display("FAIL stall: pc=%0d cnt=%0d, want 7 %0d", prog_ctr, CycleCount, c0 + 16'd3);
      end
      BranchAbs = 1; Target = 10'd100;
      step();
      clear_ctl();
      checks++;
      if (prog_ctr !== 10'd7) begin
         errors++;
         $display("FAIL stall_abs: pc=%0d, want 7", prog_ctr);
      end
   endtask

   task automatic test_wrap();
      jump_to(10'd1023);
      step();
      checks++;
      if (prog_ctr !== 10'd0) begin
         errors++;
         $display("FAIL wrap_inc: pc=%0d, want 0", prog_ctr);
      end
      jump_to(10'd2);
      BranchRel = 1; Offset = 8'hFB;
      step();
      clear_ctl();
      checks++;
      if (prog_ctr !== 10'd1021) begin
         errors++;
         $display("FAIL wrap_rel: pc=%0d, want 1021", prog_ctr);
      end
   endtask

   task automatic test_halt();
      logic [15:0] c1;
      jump_to(10'd42);
      c1 = CycleCount;
      Halt = 1; BranchAbs = 1; Target = 10'd5;
      step();
      checks++;
      if (Done !== 1'b1 || Running !== 1'b0 || prog_ctr !== 10'd42 || CycleCount !== c1 + 16'd1) begin
         errors++;
         $display("FAIL halt: done=%b run=%b pc=%0d cnt=%0d, want 1 0 42 %0d", Done, Running, prog_ctr, CycleCount, c1 + 16'd1);
      end
      Halt = 0; Stall = 0; BranchRel = 1; Offset = 8'h03;
      step(); step();
      clear_ctl();
      checks++;
      if (Done !== 1'b1 || prog_ctr !== 10'd42 || CycleCount !== c1 + 16'd1) begin
         errors++;
         $display("FAIL done_hold: done=%b pc=%0d cnt=%0d, want 1 42 %0d", Done, prog_ctr, CycleCount, c1 + 16'd1);
      end
      Start = 1;
      step();
      checks++;
      if (Done !== 1'b0 || prog_ctr !== 10'd0 || CycleCount !== 16'd0) begin
         errors++;
         $display("FAIL rearm: done=%b pc=%0d cnt=%0d, want 0 0 0", Done, prog_ctr, CycleCount);
      end
      Start = 0;
      step();
      checks++;
      if (Running !== 1'b1 || prog_ctr !== 10'd0) begin
         errors++;
         $display("FAIL rerun: run=%b pc=%0d, want 1 0", Running, prog_ctr);
      end
   endtask

   task automatic test_reset_mid_run();
      jump_to(10'd55);
      Start = 1;
      step();
      Start = 0;
      checks++;
      if (prog_ctr !== 10'd56 || Running !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored: pc=%0d run=%b, want 56 1", prog_ctr, Running);
      end
      jump_to(10'd55);
      Reset = 1; BranchAbs = 1; Target = 10'd300;
      step();
      Reset = 0; clear_ctl();
      checks++;
      if (prog_ctr !== 10'd0 || CycleCount !== 16'd0 || Done !== 1'b0 || Running !== 1'b0) begin
         errors++;
         $display("FAIL reset_run: pc=%0d cnt=%0d done=%b run=%b, want 0 0 0 0", prog_ctr, CycleCount, Done, Running);
      end
   endtask

   task automatic test_saturate();
      Start = 1;
      step();
      Start = 0;
      step();
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (CycleCount_s !== 4'd15 || CycleCount !== 16'd20) begin
         errors++;
         $display("FAIL saturate: small=%0d big=%0d, want 15 20", CycleCount_s, CycleCount);
      end
      Halt = 1;
      step();
      clear_ctl();
      step();
      checks++;
      if (CycleCount_s !== 4'd15 || Done_s !== 1'b1 || CycleCount !== 16'd21 || prog_ctr_s !== prog_ctr) begin
         errors++;
         $display("FAIL sat_done: small=%0d done=%b big=%0d, want 15 1 21", CycleCount_s, Done_s, CycleCount);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_wrap();
      test_halt();
      test_reset_mid_run();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
